// File: rtl/sipo_frame_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sipo_frame_pkg                                            |
// | Purpose  : Shared types and constants for the serial-frame receiver. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package sipo_frame_pkg;

    // Receive sequencer states; PARITY is only reachable in parity builds
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Number of flops between the asynchronous pin and the sequencer
    localparam int SYNC_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/sipo_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sipo_shift_reg                                            |
// | Purpose  : WIDTH-bit serial-in/parallel-out shift register, shifting |
// |            right with the new bit entering at the MSB.               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sipo_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             ShiftIn,
    input  logic             ShiftEn,
    output logic [WIDTH-1:0] ParallelOut,
    output logic             ShiftOut
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Shift right by one only when enabled, so the first bit ends in bit 0
    always_comb begin
        sr_d = sr_q;
        if (ShiftEn) begin
            sr_d = {ShiftIn, sr_q[WIDTH-1:1]};
        end
    end

    // Register stage with asynchronous clear
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign ParallelOut = sr_q;
    assign ShiftOut    = sr_q[0];

endmodule
`default_nettype wire

// File: rtl/sipo_frame_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sipo_frame_controller                                     |
// | Purpose  : Serial frame receiver: start-bit qualification, mid-bit   |
// |            sampling of WIDTH data bits, stop-bit check and a         |
// |            one-entry valid/ready holding register.                   |
// | Options  : define SIPO_FRAME_PARITY_EN to add an even-parity bit     |
// |            between data and stop, plus the ParityErr output.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sipo_frame_controller
    import sipo_frame_pkg::*;
#(
    parameter int WIDTH = 4,   // data bits per frame, >= 2
    parameter int DIV   = 4    // clocks per bit period, even, >= 4
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             SerialIn,
    input  logic             DataReady,
    output logic [WIDTH-1:0] Data,
    output logic             DataValid,
    output logic             FrameErr,
    output logic             Overrun,
`ifdef SIPO_FRAME_PARITY_EN
    output logic             ParityErr,
`endif
    output logic             Busy,
    output logic             ShiftEn
);

    localparam int CNT_W = $clog2(DIV);
    localparam int BIT_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);

    state_t                state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [SYNC_DEPTH-1:0] sync_q,      sync_d;
    logic [WIDTH-1:0]      data_q,      data_d;
    logic                  valid_q,     valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q,   overrun_d;
`ifdef SIPO_FRAME_PARITY_EN
    logic                  parity_bad_q, parity_bad_d;
    logic                  parity_err_q, parity_err_d;
`endif

    logic                  sin_s;
    logic                  shift_en;
    logic                  frame_good;
    logic [WIDTH-1:0]      sr_word;
    logic                  sr_shift_out_unused;  // serial-out has no consumer here

    assign sin_s = sync_q[SYNC_DEPTH-1];

    sipo_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .Clk         (Clk),
        .reset_n     (reset_n),
        .ShiftIn     (sin_s),
        .ShiftEn     (shift_en),
        .ParallelOut (sr_word),
        .ShiftOut    (sr_shift_out_unused)
    );

    // Move the pin through the synchronizer chain, oldest bit at the top
    always_comb begin
        sync_d = {sync_q[SYNC_DEPTH-2:0], SerialIn};
    end

    // Sequencer: next state, bit timing, shift pulses and handshake update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_en    = 1'b0;
        data_d      = data_q;
        valid_d     = valid_q & ~DataReady;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        frame_good  = 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
        parity_bad_d = parity_bad_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!sin_s) begin
                    state_d = START;
                end
            end

            START: begin
                // Re-check the line at mid start bit to reject glitches
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = sin_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d    = '0;
                    shift_en = 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef SIPO_FRAME_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end

`ifdef SIPO_FRAME_PARITY_EN
            PARITY: begin
                // Even parity: data bits plus parity bit must hold an even count of ones
                if (cnt_q == FULL_LAST) begin
                    cnt_d        = '0;
                    parity_bad_d = ^{sr_word, sin_s};
                    state_d      = STOP;
                end
            end
`endif

            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d       = '0;
                    state_d     = IDLE;
                    frame_err_d = ~sin_s;
`ifdef SIPO_FRAME_PARITY_EN
                    parity_err_d = parity_bad_q;
                    frame_good   = sin_s & ~parity_bad_q;
`else
                    frame_good   = sin_s;
`endif
                    if (frame_good) begin
                        if (!valid_q || DataReady) begin
                            data_d  = sr_word;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously so a reset aborts any frame
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            sync_q       <= '1;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            sync_q       <= sync_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef SIPO_FRAME_PARITY_EN
            parity_bad_q <= parity_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign Data      = data_q;
    assign DataValid = valid_q;
    assign FrameErr  = frame_err_q;
    assign Overrun   = overrun_q;
`ifdef SIPO_FRAME_PARITY_EN
    assign ParityErr = parity_err_q;
`endif
    assign Busy      = (state_q != IDLE);
    assign ShiftEn   = shift_en;

endmodule
`default_nettype wire

// File: tb/tb_sipo_frame_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_sipo_frame_controller                                  |
// | Purpose  : Self-checking bench: frames are modelled as transactions  |
// |            with their decision edge, busy window and mid-bit shift   |
// |            edges derived from the frame timing rules.                |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_sipo_frame_controller;

    localparam int WIDTH = 4;
    localparam int DIV   = 4;
`ifdef SIPO_FRAME_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Edges from the first low sample of the start bit to the load edge
    localparam int LAT = 2 + DIV / 2 + (WIDTH + 1 + PB) * DIV;

    logic             Clk = 1'b0;
    logic             reset_n;
    logic             SerialIn;
    logic             DataReady;
    logic [WIDTH-1:0] Data;
    logic             DataValid;
    logic             FrameErr;
    logic             Overrun;
    logic             Busy;
    logic             ShiftEn;
`ifdef SIPO_FRAME_PARITY_EN
    logic             ParityErr;
`endif

    sipo_frame_controller #(
        .WIDTH (WIDTH),
        .DIV   (DIV)
    ) dut (
        .Clk       (Clk),
        .reset_n   (reset_n),
        .SerialIn  (SerialIn),
        .DataReady (DataReady),
        .Data      (Data),
        .DataValid (DataValid),
        .FrameErr  (FrameErr),
        .Overrun   (Overrun),
`ifdef SIPO_FRAME_PARITY_EN
        .ParityErr (ParityErr),
`endif
        .Busy      (Busy),
        .ShiftEn   (ShiftEn)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int               dec;
        logic [WIDTH-1:0] word;
        bit               stop;
        bit               par_ok;
    } frame_t;

    typedef struct {
        int lo;
        int hi;
    } win_t;

    frame_t fq[$];
    win_t   bq[$];
    bit     shift_at[int];

    int               n_cmp = 0;
    int               n_bad = 0;
    int               edge_cnt = 0;
    int               sh_cnt = 0;
    int               last_rise = -1;
    int               last_e0 = 0;
    logic             prev_valid = 1'b0;
    logic             rdy_e;
    bit               rdy_random = 0;
    logic             exp_valid = 1'b0;
    logic [WIDTH-1:0] exp_data = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, edge_cnt, got, exp);
        end
    endtask

    task automatic model_clear();
        fq.delete();
        bq.delete();
        shift_at.delete();
        exp_valid = 1'b0;
        exp_data  = '0;
    endtask

    // Advance the reference model by one edge and compare every output
    task automatic model_check();
        frame_t f;
        bit     fe, ov, se, bz, load;
`ifdef SIPO_FRAME_PARITY_EN
        bit     pe;
        pe = 0;
`endif
        fe = 0; ov = 0; load = 0; bz = 0;
        if (!reset_n) begin
            model_clear();
        end else begin
            if (fq.size() > 0 && fq[0].dec == edge_cnt) begin
                f  = fq.pop_front();
                fe = !f.stop;
`ifdef SIPO_FRAME_PARITY_EN
                pe = !f.par_ok;
`endif
                if (f.stop && f.par_ok) begin
                    if (!exp_valid || rdy_e) begin
                        load     = 1;
                        exp_data = f.word;
                    end else begin
                        ov = 1;
                    end
                end
            end
            if (load) exp_valid = 1'b1;
            else if (exp_valid && rdy_e) exp_valid = 1'b0;
        end
        se = shift_at.exists(edge_cnt);
        if (se) shift_at.delete(edge_cnt);
        foreach (bq[i]) if (edge_cnt >= bq[i].lo && edge_cnt <= bq[i].hi) bz = 1;
        while (bq.size() > 0 && bq[0].hi < edge_cnt) void'(bq.pop_front());

        check_eq("valid",     32'(DataValid), 32'(exp_valid));
        check_eq("data",      32'(Data),      32'(exp_data));
        check_eq("frame_err", 32'(FrameErr),  32'(fe));
        check_eq("overrun",   32'(Overrun),   32'(ov));
        check_eq("shift_en",  32'(ShiftEn),   32'(se));
        check_eq("busy",      32'(Busy),      32'(bz));
`ifdef SIPO_FRAME_PARITY_EN
        check_eq("parity_err", 32'(ParityErr), 32'(pe));
`endif
    endtask

    task automatic tick();
        @(posedge Clk);
        rdy_e = DataReady;
        edge_cnt++;
        #1;
        model_check();
        if (ShiftEn) sh_cnt++;
        if (DataValid && !prev_valid) last_rise = edge_cnt;
        prev_valid = DataValid;
        if (rdy_random) DataReady = ($urandom_range(0, 3) != 0);
    endtask

    // Asynchronous reset in the middle of a cycle, held for a few edges
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        check_eq("rst_busy",  32'(Busy),      32'd0);
        check_eq("rst_valid", 32'(DataValid), 32'd0);
        check_eq("rst_data",  32'(Data),      32'd0);
        check_eq("rst_shift", 32'(ShiftEn),   32'd0);
        check_eq("rst_ferr",  32'(FrameErr),  32'd0);
        check_eq("rst_ovr",   32'(Overrun),   32'd0);
        SerialIn = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic drive_seg(input logic v, input int dur, input int abort_at,
                             inout int n, inout bit aborted);
        if (aborted) return;
        SerialIn = v;
        repeat (dur) begin
            if (abort_at > 0 && n == abort_at) begin
                do_reset();
                aborted = 1;
                return;
            end
            tick();
            n++;
        end
    endtask

    // Send one frame; a low stop bit is held just past its mid-bit sample
    task automatic send_frame(input logic [WIDTH-1:0] w, input bit stop_b,
                              input bit par_b, input int abort_at);
        frame_t f;
        win_t   bw;
        int     e0, n;
        bit     aborted;
        e0 = edge_cnt + 1;
        last_e0  = e0;
        f.dec    = e0 + LAT;
        f.word   = w;
        f.stop   = stop_b;
        f.par_ok = (PB == 0) || (par_b == ^w);
        fq.push_back(f);
        bw.lo = e0 + 2;
        bw.hi = e0 + LAT - 1;
        bq.push_back(bw);
        for (int k = 0; k < WIDTH; k++) shift_at[e0 + 1 + DIV / 2 + (k + 1) * DIV] = 1;
        n = 0;
        aborted = 0;
        drive_seg(1'b0, DIV, abort_at, n, aborted);
        for (int k = 0; k < WIDTH; k++) drive_seg(w[k], DIV, abort_at, n, aborted);
        if (PB != 0) drive_seg(par_b, DIV, abort_at, n, aborted);
        if (stop_b) begin
            drive_seg(1'b1, DIV, abort_at, n, aborted);
        end else begin
            drive_seg(1'b0, DIV / 2 + 1, abort_at, n, aborted);
            drive_seg(1'b1, DIV / 2 - 1, abort_at, n, aborted);
        end
    endtask

    task automatic send_glitch();
        win_t bw;
        int   g0;
        g0 = edge_cnt + 1;
        bw.lo = g0 + 2;
        bw.hi = g0 + 1 + DIV / 2;
        bq.push_back(bw);
        SerialIn = 1'b0;
        tick();
        SerialIn = 1'b1;
        repeat (2 * DIV) tick();
    endtask

    initial begin
        int               sh0;
        logic [WIDTH-1:0] w;
        bit               st, pg;

        reset_n   = 1'b0;
        SerialIn  = 1'b1;
        DataReady = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (4) tick();

        // Single good frame 0xA with the consumer always ready
        sh0 = sh_cnt;
        w = 4'hA;
        send_frame(w, 1'b1, ^w, 0);
        repeat (8) tick();
        check_eq("latency",   32'(last_rise - last_e0), 32'(LAT));
        check_eq("shift_cnt", 32'(sh_cnt - sh0),        32'(WIDTH));

        // One-cycle low glitch is rejected
        sh0 = sh_cnt;
        send_glitch();
        check_eq("glitch_shift", 32'(sh_cnt - sh0), 32'd0);

        // Framing error on 0x3
        w = 4'h3;
        send_frame(w, 1'b0, ^w, 0);
        repeat (4) tick();

        // Backpressure: second back-to-back frame overruns
        DataReady = 1'b0;
        w = 4'h5;
        send_frame(w, 1'b1, ^w, 0);
        w = 4'hC;
        send_frame(w, 1'b1, ^w, 0);
        repeat (6) tick();
        check_eq("held_data", 32'(Data), 32'h5);
        DataReady = 1'b1;
        tick();
        DataReady = 1'b0;
        repeat (3) tick();
        DataReady = 1'b1;

`ifdef SIPO_FRAME_PARITY_EN
        // Bad then good even parity on 0x7
        w = 4'h7;
        send_frame(w, 1'b1, 1'b0, 0);
        repeat (4) tick();
        send_frame(w, 1'b1, 1'b1, 0);
        repeat (6) tick();
`endif

        // Reset in the middle of a frame, then a clean frame
        w = 4'h9;
        send_frame(w, 1'b1, ^w, 10);
        repeat (4) tick();
        w = 4'h6;
        send_frame(w, 1'b1, ^w, 0);
        repeat (8) tick();

        // Randomized frames, gaps, stop/parity errors and consumer stalls
        rdy_random = 1;
        for (int i = 0; i < 40; i++) begin
            w  = WIDTH'($urandom);
            st = ($urandom_range(0, 9) != 0);
            pg = ($urandom_range(0, 3) != 0);
            send_frame(w, st, pg ? ^w : ~^w, 0);
            repeat ($urandom_range(0, 2 * DIV)) tick();
        end
        rdy_random = 0;
        DataReady  = 1'b1;
        repeat (LAT + DIV) tick();
        check_eq("pending", 32'(fq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
